// File: rtl/canonical_code_gen.sv
// canonical_code_gen
// Builds a canonical prefix-code table from a list of per-symbol code lengths.
// Lengths are streamed in symbol order. The per-length counts are converted
// into first-code values and the code set is checked against the Kraft
// inequality. Unless an error was found, one (symbol, length, code) entry per
// symbol is emitted through a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       begin a new build (honoured only when idle)
//   len_valid   len_in carries the length of the next symbol
//   len_in      code length, 0 = unused symbol
//   code_ready  downstream accepts the current entry
//   code_valid  code_sym/code_len/code hold a valid entry
//   code_sym    symbol index of the entry
//   code_len    code length of the entry
//   code        canonical code, right-aligned
//   busy        high whenever not idle
//   done        one-cycle pulse at the end of a build
//   err         invalid length set; valid with done, held until next start
module canonical_code_gen #(
    parameter int unsigned NUM_SYM = 8,
    parameter int unsigned MAX_LEN = 7,
    localparam int unsigned SYM_W = $clog2(NUM_SYM),
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               len_valid,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               code_ready,
    output logic               code_valid,
    output logic [SYM_W-1:0]   code_sym,
    output logic [LEN_W-1:0]   code_len,
    output logic [MAX_LEN-1:0] code,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned ACC_W = MAX_LEN + SYM_W + 1;
    localparam int unsigned CNT_W = SYM_W + 1;
    // Tables are sized to the full index range so any index value is in bounds.
    localparam int unsigned LEN_N = 2 ** LEN_W;
    localparam int unsigned SYM_N = 2 ** SYM_W;

    localparam logic [SYM_W-1:0] LAST_SYM  = SYM_W'(NUM_SYM - 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {StIdle, StLoad, StNext, StEmit, StFin} state_e;

    state_e             state_q;
    logic [SYM_W-1:0]   ld_idx_q;
    logic [LEN_W-1:0]   bit_idx_q;
    logic [ACC_W-1:0]   code_acc_q;
    logic [ACC_W-1:0]   kraft_q;
    logic [LEN_W-1:0]   len_tab_q   [SYM_N];
    logic [CNT_W-1:0]   bl_count_q  [LEN_N];
    logic [MAX_LEN-1:0] next_code_q [LEN_N];

    logic               len_bad;
    logic [ACC_W-1:0]   acc_new;
    logic [ACC_W-1:0]   kraft_new;
    logic               kraft_over;
    logic [LEN_W-1:0]   first_len;
    logic [MAX_LEN-1:0] first_code;
    logic [SYM_W-1:0]   nxt_sym;
    logic [LEN_W-1:0]   nxt_len;
    logic [MAX_LEN-1:0] nxt_code;

    // Only reachable when MAX_LEN+1 is not a power of two.
    assign len_bad = {1'b0, len_in} > {1'b0, MAX_LEN_L};

    // bl_count[0] is never incremented, so bit_idx=1 adds zero.
    assign acc_new    = (code_acc_q + ACC_W'(bl_count_q[bit_idx_q - LEN_W'(1)])) << 1;
    assign kraft_new  = kraft_q + (ACC_W'(bl_count_q[bit_idx_q]) << (MAX_LEN_L - bit_idx_q));
    assign kraft_over = kraft_new > (ACC_W'(1) << MAX_LEN);

    // Symbol 0 is presented on the same edge that writes next_code[MAX_LEN],
    // so forward the value being written.
    always_comb begin
        first_len  = len_tab_q[0];
        first_code = '0;
        if (first_len == bit_idx_q) begin
            first_code = acc_new[MAX_LEN-1:0];
        end else if (first_len != '0) begin
            first_code = next_code_q[first_len];
        end
    end

    // Following entry; if it shares the length just handshaken, forward the
    // incremented code instead of the stale table value.
    always_comb begin
        nxt_sym  = code_sym + SYM_W'(1);
        nxt_len  = len_tab_q[nxt_sym];
        nxt_code = '0;
        if (nxt_len != '0) begin
            if (nxt_len == code_len) begin
                nxt_code = code + MAX_LEN'(1);
            end else begin
                nxt_code = next_code_q[nxt_len];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ld_idx_q   <= '0;
            bit_idx_q  <= '0;
            code_acc_q <= '0;
            kraft_q    <= '0;
            code_valid <= 1'b0;
            code_sym   <= '0;
            code_len   <= '0;
            code       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < int'(SYM_N); i++) begin
                len_tab_q[i] <= '0;
            end
            for (int i = 0; i < int'(LEN_N); i++) begin
                bl_count_q[i]  <= '0;
                next_code_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StLoad;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        ld_idx_q <= '0;
                        for (int i = 0; i < int'(LEN_N); i++) begin
                            bl_count_q[i] <= '0;
                        end
                    end
                end

                StLoad: begin
                    if (len_valid) begin
                        if (len_bad) begin
                            err                 <= 1'b1;
                            len_tab_q[ld_idx_q] <= '0;
                        end else begin
                            len_tab_q[ld_idx_q] <= len_in;
                            if (len_in != '0) begin
                                bl_count_q[len_in] <= bl_count_q[len_in] + CNT_W'(1);
                            end
                        end
                        ld_idx_q <= ld_idx_q + SYM_W'(1);
                        if (ld_idx_q == LAST_SYM) begin
                            state_q    <= StNext;
                            bit_idx_q  <= LEN_W'(1);
                            code_acc_q <= '0;
                            kraft_q    <= '0;
                        end
                    end
                end

                StNext: begin
                    next_code_q[bit_idx_q] <= acc_new[MAX_LEN-1:0];
                    code_acc_q             <= acc_new;
                    kraft_q                <= kraft_new;
                    bit_idx_q              <= bit_idx_q + LEN_W'(1);
                    if (bit_idx_q == MAX_LEN_L) begin
                        if (err || kraft_over) begin
                            err     <= 1'b1;
                            state_q <= StFin;
                            done    <= 1'b1;
                        end else begin
                            state_q    <= StEmit;
                            code_valid <= 1'b1;
                            code_sym   <= '0;
                            code_len   <= first_len;
                            code       <= first_code;
                        end
                    end
                end

                StEmit: begin
                    // code_valid is always high in this state.
                    if (code_ready) begin
                        if (code_len != '0) begin
                            next_code_q[code_len] <= code + MAX_LEN'(1);
                        end
                        if (code_sym == LAST_SYM) begin
                            code_valid <= 1'b0;
                            code_sym   <= '0;
                            code_len   <= '0;
                            code       <= '0;
                            state_q    <= StFin;
                            done       <= 1'b1;
                        end else begin
                            code_sym <= nxt_sym;
                            code_len <= nxt_len;
                            code     <= nxt_code;
                        end
                    end
                end

                StFin: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_canonical_code_gen.sv
module tb_canonical_code_gen;

    localparam int NUM_SYM = 8;
    localparam int MAX_LEN = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         len_valid;
    logic [2:0]   len_in;
    logic         code_ready;
    logic         code_valid;
    logic [2:0]   code_sym;
    logic [2:0]   code_len;
    logic [6:0]   code;
    logic         busy;
    logic         done;
    logic         err;

    canonical_code_gen #(
        .NUM_SYM(NUM_SYM),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len_valid (len_valid),
        .len_in    (len_in),
        .code_ready(code_ready),
        .code_valid(code_valid),
        .code_sym  (code_sym),
        .code_len  (code_len),
        .code      (code),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int in_len   [8];
    int exp_len  [8];
    int exp_code [8];
    int rdy_pat  [4] = '{1, 0, 0, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid0"}, 32'(code_valid), 32'd0);
        check({name, "_sym0"},   32'(code_sym),   32'd0);
        check({name, "_len0"},   32'(code_len),   32'd0);
        check({name, "_code0"},  32'(code),       32'd0);
        check({name, "_busy0"},  32'(busy),       32'd0);
        check({name, "_done0"},  32'(done),       32'd0);
        check({name, "_err0"},   32'(err),        32'd0);
    endtask

    // One full build: load in_len[], then collect entries against exp_len[]/exp_code[].
    // rst_after > 0 resets the DUT once that many entries have been accepted.
    task automatic run_build(input bit gaps, input bit rdy_toggle, input bit start_emit,
                             input int rst_after, input bit exp_err, input string name);
        int         idx = 0;
        int         vcnt = 0;
        int         cyc = 0;
        int         rp = 0;
        bit         hold = 0;
        bit         last_pending = 0;
        bit         done_seen = 0;
        logic [2:0] h_sym = '0;
        logic [2:0] h_len = '0;
        logic [6:0] h_code = '0;

        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy_load"}, 32'(busy), 32'd1);

        for (int i = 0; i < NUM_SYM; i++) begin
            if (gaps && (i % 2 == 1)) begin
                len_valid = 1'b0;
                len_in    = 3'd7;
                tick();
            end
            len_valid = 1'b1;
            len_in    = 3'(in_len[i]);
            tick();
        end
        len_valid = 1'b0;
        len_in    = '0;

        while (cyc < 200 && !done_seen) begin
            if (last_pending) begin
                check({name, "_done_pulse"}, 32'(done), 32'd1);
                check({name, "_valid_after"}, 32'(code_valid), 32'd0);
                last_pending = 0;
            end
            if (done) begin
                done_seen = 1;
                break;
            end
            code_ready = rdy_toggle ? (rdy_pat[rp % 4] != 0) : 1'b1;
            rp++;
            start = start_emit && code_valid && (idx == 2);
            if (hold && code_valid) begin
                check({name, "_hold_sym"},  32'(code_sym), 32'(h_sym));
                check({name, "_hold_len"},  32'(code_len), 32'(h_len));
                check({name, "_hold_code"}, 32'(code),     32'(h_code));
            end
            if (code_valid) begin
                vcnt++;
                if (code_ready) begin
                    if (idx < NUM_SYM) begin
                        check($sformatf("%s_sym%0d", name, idx),  32'(code_sym), 32'(idx));
                        check($sformatf("%s_len%0d", name, idx),  32'(code_len), 32'(exp_len[idx]));
                        check($sformatf("%s_code%0d", name, idx), 32'(code),     32'(exp_code[idx]));
                    end
                    idx++;
                    hold = 0;
                    if (idx == NUM_SYM) last_pending = 1;
                end else begin
                    hold   = 1;
                    h_sym  = code_sym;
                    h_len  = code_len;
                    h_code = code;
                end
            end else begin
                hold = 0;
            end
            tick();
            cyc++;
            if (rst_after > 0 && idx == rst_after) begin
                start      = 1'b0;
                code_ready = 1'b1;
                rst        = 1'b1;
                tick();
                rst = 1'b0;
                check_all_zero({name, "_rst"});
                return;
            end
        end
        start = 1'b0;

        check({name, "_done_seen"}, 32'(done_seen), 32'd1);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        if (exp_err) begin
            check({name, "_no_valid"}, 32'(vcnt), 32'd0);
        end else begin
            check({name, "_entries"}, 32'(idx), 32'(NUM_SYM));
        end
        tick();
        check({name, "_done_clear"}, 32'(done), 32'd0);
        check({name, "_busy_idle"},  32'(busy), 32'd0);
        check({name, "_err_held"},   32'(err),  32'(exp_err));
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        len_valid  = 1'b0;
        len_in     = '0;
        code_ready = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Mixed lengths, always ready.
        in_len   = '{3, 3, 3, 3, 3, 2, 4, 4};
        exp_len  = '{3, 3, 3, 3, 3, 2, 4, 4};
        exp_code = '{2, 3, 4, 5, 6, 0, 14, 15};
        run_build(0, 0, 0, -1, 0, "mixed");

        // Over-subscribed set: Kraft sum 192 > 128.
        in_len = '{1, 1, 1, 0, 0, 0, 0, 0};
        run_build(0, 0, 0, -1, 1, "kraft");

        // All unused; err must also clear on the new start.
        in_len   = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_len  = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_code = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_build(0, 0, 0, -1, 0, "zero");

        // Same table with input gaps and back-pressure.
        in_len   = '{3, 3, 3, 3, 3, 2, 4, 4};
        exp_len  = '{3, 3, 3, 3, 3, 2, 4, 4};
        exp_code = '{2, 3, 4, 5, 6, 0, 14, 15};
        run_build(1, 1, 0, -1, 0, "stall");

        // Reset after symbol 3 is accepted, then a full rebuild.
        run_build(0, 0, 0, 4, 0, "midrst");
        run_build(0, 0, 0, -1, 0, "rebuild");

        // Single used symbol; start pulsed during emission.
        in_len   = '{0, 0, 0, 0, 0, 0, 0, 5};
        exp_len  = '{0, 0, 0, 0, 0, 0, 0, 5};
        exp_code = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_build(0, 0, 1, -1, 0, "single");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
